// File: rtl/uart_apb_sequencer_pkg.sv
// Shared definitions for the UART APB sequencer: register map, status bits,
// FSM state encodings and the APB command bundle.
package uart_apb_sequencer_pkg;

    localparam logic [4:0] ADDR_TXDATA  = 5'h00;
    localparam logic [4:0] ADDR_RXDATA  = 5'h04;
    localparam logic [4:0] ADDR_BAUD_LO = 5'h08;
    localparam logic [4:0] ADDR_BAUD_HI = 5'h0C;
    localparam logic [4:0] ADDR_STATUS  = 5'h10;

    localparam int STAT_TXRDY_BIT = 0;
    localparam int STAT_RXRDY_BIT = 1;

    typedef enum logic [2:0] {
        CFG1 = 3'd0,
        CFG2 = 3'd1,
        POLL = 3'd2,
        RXRD = 3'd3,
        TXWR = 3'd4
    } seq_state_e;

    // Encoding doubles as {PSEL, PENABLE}.
    typedef enum logic [1:0] {
        XF_IDLE   = 2'b00,
        XF_SETUP  = 2'b10,
        XF_ACCESS = 2'b11
    } xfer_state_e;

    typedef struct packed {
        logic [4:0] addr;
        logic       write;
        logic [7:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/uart_apb_sequencer_xfer.sv
// Single APB master transfer engine: SETUP then ACCESS until PREADY, with
// address/direction/data latched at start and a completion strobe.
module uart_apb_xfer
    import uart_apb_sequencer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  apb_cmd_t   cmd_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       slverr_o,
    output logic       psel_o,
    output logic       penable_o,
    output logic [4:0] paddr_o,
    output logic       pwrite_o,
    output logic [7:0] pwdata_o,
    input  logic [7:0] prdata_i,
    input  logic       pready_i,
    input  logic       pslverr_i
);

    xfer_state_e state_q, state_d;
    apb_cmd_t    cmd_q, cmd_d;

    // Transfer state and latched command.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= XF_IDLE;
            cmd_q   <= '{addr: 5'h00, write: 1'b0, wdata: 8'h00};
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    // Handshake sequencing.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            XF_IDLE: begin
                if (start_i) begin
                    state_d = XF_SETUP;
                    cmd_d   = cmd_i;
                end else begin
                    state_d = XF_IDLE;
                end
            end
            XF_SETUP:  state_d = XF_ACCESS;
            XF_ACCESS: begin
                if (pready_i) begin
                    state_d = XF_IDLE;
                end else begin
                    state_d = XF_ACCESS;
                end
            end
            default:   state_d = XF_IDLE;
        endcase
    end

    assign psel_o    = state_q[1];
    assign penable_o = state_q[0];
    assign busy_o    = state_q[1];
    assign paddr_o   = cmd_q.addr;
    assign pwrite_o  = cmd_q.write;
    assign pwdata_o  = cmd_q.wdata;
    assign done_o    = (state_q == XF_ACCESS) && pready_i;
    assign rdata_o   = prdata_i;
    assign slverr_o  = pslverr_i;

endmodule

// File: rtl/uart_apb_sequencer.sv
// Configures a UART over APB, then polls status and moves bytes between
// round-robin TX requesters and the UART. RX path enabled by UART_SEQ_RX_EN.
module uart_apb_sequencer
    import uart_apb_sequencer_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter logic [2:0]  CFG_MODE   = 3'b001
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    output logic                 cfg_done,
    output logic                 err,
    output logic [4:0]           PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [7:0]           PWDATA,
    input  logic [7:0]           PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int GW = $clog2(NUM_REQ);

    seq_state_e  state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        cfg_done_q, cfg_done_d;
    logic        err_q, err_d;
    apb_cmd_t    cmd_s;
    logic        busy_s, done_s, slverr_s;
    logic [7:0]  rdata_s;
    logic [GW-1:0] rr_grant_s;

    // Nearest valid requester after 'last', wrapping modulo NUM_REQ.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic [GW-1:0] idx;
        int            s;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            s   = int'(last) + k;
            s   = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
            idx = GW'(s);
            if (valid[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign rr_grant_s = rr_pick(req_valid, last_grant_q);

    uart_apb_xfer u_xfer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .start_i   (!busy_s),
        .cmd_i     (cmd_s),
        .busy_o    (busy_s),
        .done_o    (done_s),
        .rdata_o   (rdata_s),
        .slverr_o  (slverr_s),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .paddr_o   (PADDR),
        .pwrite_o  (PWRITE),
        .pwdata_o  (PWDATA),
        .prdata_i  (PRDATA),
        .pready_i  (PREADY),
        .pslverr_i (PSLVERR)
    );

`ifdef UART_SEQ_RX_EN
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;

    // Received byte capture.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
`else
    logic unused_rdata_s;
    assign unused_rdata_s = ^rdata_s[7:1];
    assign rx_valid       = 1'b0;
    assign rx_data        = 8'h00;
`endif

    // Sequencer state and bookkeeping.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= CFG1;
            grant_q      <= GW'(NUM_REQ - 1);
            last_grant_q <= GW'(NUM_REQ - 1);
            tx_byte_q    <= 8'h00;
            cfg_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tx_byte_q    <= tx_byte_d;
            cfg_done_q   <= cfg_done_d;
            err_q        <= err_d;
        end
    end

    // Next state, per-state APB command and side effects of completion.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tx_byte_d    = tx_byte_q;
        cfg_done_d   = cfg_done_q;
        err_d        = err_q | (done_s & slverr_s);
        cmd_s        = '{addr: ADDR_STATUS, write: 1'b0, wdata: 8'h00};
`ifdef UART_SEQ_RX_EN
        rx_valid_d   = 1'b0;
        rx_data_d    = rx_data_q;
`endif
        case (state_q)
            CFG1: begin
                cmd_s = '{addr: ADDR_BAUD_LO, write: 1'b1, wdata: BAUD_VALUE[7:0]};
                if (done_s) begin
                    state_d = CFG2;
                end else begin
                    state_d = CFG1;
                end
            end
            CFG2: begin
                cmd_s = '{addr: ADDR_BAUD_HI, write: 1'b1,
                          wdata: {BAUD_VALUE[12:8], CFG_MODE}};
                if (done_s) begin
                    state_d    = POLL;
                    cfg_done_d = 1'b1;
                end else begin
                    state_d = CFG2;
                end
            end
            POLL: begin
                if (!done_s) begin
                    state_d = POLL;
`ifdef UART_SEQ_RX_EN
                end else if (rdata_s[STAT_RXRDY_BIT]) begin
                    state_d = RXRD;
`endif
                end else if (rdata_s[STAT_TXRDY_BIT] && (|req_valid)) begin
                    state_d   = TXWR;
                    grant_d   = rr_grant_s;
                    tx_byte_d = req_data[{rr_grant_s, 3'b000} +: 8];
                end else begin
                    state_d = POLL;
                end
            end
`ifdef UART_SEQ_RX_EN
            RXRD: begin
                cmd_s = '{addr: ADDR_RXDATA, write: 1'b0, wdata: 8'h00};
                if (done_s) begin
                    state_d    = POLL;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rdata_s;
                end else begin
                    state_d = RXRD;
                end
            end
`endif
            TXWR: begin
                cmd_s = '{addr: ADDR_TXDATA, write: 1'b1, wdata: tx_byte_q};
                if (done_s) begin
                    state_d      = POLL;
                    last_grant_d = grant_q;
                end else begin
                    state_d = TXWR;
                end
            end
            default: state_d = CFG1;
        endcase
    end

    // req_ready must coincide with the completing ACCESS cycle, hence combinational.
    assign req_ready = (state_q == TXWR && done_s) ? (NUM_REQ'(1) << grant_q) : '0;
    assign cfg_done  = cfg_done_q;
    assign err       = err_q;

endmodule

// File: doc/uart_apb_sequencer.md
UART_APB_SEQUENCER -- requirements
Module: uart_apb_sequencer

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of byte-stream requesters (legal range 2..8).
REQ-002 SHALL have parameter BAUD_VALUE, default 13'd1, giving the 13-bit baud divisor written at init.
REQ-003 SHALL have parameter CFG_MODE, default 3'b001, giving the {odd_n_even, parity_en, bit8} line format.
REQ-004 SHALL have port PCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port PRESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports req_valid (input, NUM_REQ), req_data (input, 8*NUM_REQ; byte i at [8i+7:8i]) and req_ready (output, NUM_REQ): the TX byte requests.
REQ-007 SHALL have ports rx_valid (output, 1) and rx_data (output, 8): received byte strobe and data.
REQ-008 SHALL have ports cfg_done (output, 1) and err (output, 1): init complete, and sticky PSLVERR seen.
REQ-009 SHALL have APB master ports PADDR (output, 5), PSEL, PENABLE, PWRITE (outputs, 1 each), PWDATA (output, 8), PRDATA (input, 8), PREADY and PSLVERR (inputs, 1 each).

Function
REQ-010 Every APB transfer SHALL be a SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS cycles (PSEL=1, PENABLE=1) until PREADY=1; PADDR, PWRITE and PWDATA SHALL be held stable throughout; there SHALL be no back-to-back transfer without an intervening SETUP.
REQ-011 The main FSM SHALL use states CFG1, CFG2, POLL, RXRD, TXWR; CFG1 is the state entered from reset.
REQ-012 CFG1 SHALL write BAUD_VALUE[7:0] to 0x08; CFG2 SHALL write {BAUD_VALUE[12:8], CFG_MODE} to 0x0C; cfg_done SHALL rise in the cycle after CFG2 completes and stay high until reset.
REQ-013 POLL SHALL read status at 0x10; status bit1 = RXRDY, bit0 = TXRDY are sampled on PRDATA at the completing ACCESS cycle.
REQ-014 After POLL: if RXRDY=1, go to RXRD (RX has priority); else if TXRDY=1 and any req_valid=1, go to TXWR; otherwise repeat POLL.
REQ-015 RXRD SHALL read 0x04; in the cycle after completion, rx_valid SHALL pulse high for exactly 1 cycle with rx_data = the sampled PRDATA; rx_data SHALL hold until the next capture; next state is POLL.
REQ-016 On entry to TXWR the grant SHALL be latched: round-robin, searching from (last_grant+1) mod NUM_REQ. The granted byte SHALL be written to 0x00, and req_ready[grant] SHALL pulse for 1 cycle on the completing ACCESS cycle; next state is POLL.
REQ-017 Requesters SHALL hold req_valid and req_data until req_ready; withdrawal before grant is legal; the latched byte is used even if req_data changes mid-transfer.
REQ-018 last_grant SHALL update only on TXWR completion and wrap from NUM_REQ-1 to 0; a single active requester SHALL be served every TXWR.
REQ-019 Any completing transfer with PSLVERR=1 SHALL set err, which is sticky; the FSM SHALL proceed as if the transfer succeeded.
REQ-020 No TXWR SHALL occur without a POLL that observed TXRDY=1 immediately before it.

Reset
REQ-021 While PRESET=1: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, req_ready=0, rx_valid=0, rx_data=0, cfg_done=0, err=0, last_grant=NUM_REQ-1, state=CFG1.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer immediately; after release, the sequence SHALL restart at CFG1 with no req_ready pulse for the aborted byte.

Configuration
REQ-023 Macro UART_SEQ_RX_EN defined: RX behaviour is per REQ-014/015.
REQ-024 Macro UART_SEQ_RX_EN undefined: RXRD SHALL be absent, RXRDY SHALL be ignored, rx_valid and rx_data SHALL be constant 0, and the ports SHALL remain.

Structure
REQ-025 A shared package SHALL hold the register offsets (0x00, 0x04, 0x08, 0x0C, 0x10), the status bit indices and the FSM state enum.
REQ-026 The APB master handshake (SETUP/ACCESS, hold, completion strobe) SHALL be one sub-module, uart_apb_xfer, driven by a start pulse with addr, write and wdata, and returning done, rdata and slverr.

Verification
REQ-027 Reset release with a PREADY=1 slave: the first transfers are a write of 0x08 with BAUD_VALUE[7:0], then a write of 0x0C with {BAUD_VALUE[12:8], CFG_MODE}; cfg_done=1 one cycle after the second completes.
REQ-028 Status 0x01 with req_valid=4'b1111 and data 0xA0..0xA3: the TX writes are 0xA0, 0xA1, 0xA2, 0xA3, 0xA0, in order, each followed by its own req_ready pulse.
REQ-029 Status 0x03 with a pending request: the 0x04 read precedes the 0x00 write; rx_valid pulses once with PRDATA 0x5A captured on rx_data.
REQ-030 PREADY held low 3 cycles per transfer: PENABLE stays high 4 cycles with PADDR and PWDATA stable; there is no extra req_ready pulse.
REQ-031 PSLVERR=1 on one status read: err=1 and stays 1; polling continues.
REQ-032 PRESET pulsed during a TX ACCESS cycle: PSEL drops immediately, no req_ready pulse occurs, and the next transfer is the 0x08 write.
